// File: rtl/connect_pkg.sv
`default_nettype none
// ============================================================================
// Module  : connect_pkg
// Brief   : Shared cell/result encodings, scan directions and FSM states for
//           the connect-N engine.
// Rev     : 1.0  initial release
// ============================================================================
package connect_pkg;

    localparam logic [1:0] c_cell_empty = 2'b00;
    localparam logic [1:0] c_cell_g     = 2'b01;
    localparam logic [1:0] c_cell_o     = 2'b10;

    localparam logic [1:0] c_res_none   = 2'b00;
    localparam logic [1:0] c_res_g_win  = 2'b01;
    localparam logic [1:0] c_res_o_win  = 2'b10;
    localparam logic [1:0] c_res_draw   = 2'b11;

    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_D1 = 2'd2,
        DIR_D2 = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLACE    = 3'd1,
        ST_SCAN_FWD = 3'd2,
        ST_SCAN_BWD = 3'd3,
        ST_NEXT_DIR = 3'd4,
        ST_REPORT   = 3'd5,
        ST_REJECT   = 3'd6
    } state_e;

    // Forward step vector (dr,dc) of each scan direction
    function automatic logic signed [1:0] dir_dr(input dir_e d);
        return (d == DIR_H) ? 2'sb00 : 2'sb01;
    endfunction

    function automatic logic signed [1:0] dir_dc(input dir_e d);
        logic signed [1:0] v;
        case (d)
            DIR_H:   v = 2'sb01;
            DIR_V:   v = 2'sb00;
            DIR_D1:  v = 2'sb01;
            default: v = 2'sb11;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_board.sv
`default_nettype none
// ============================================================================
// Module  : cell_board
// Brief   : ROWS x COLS board of 2-bit cells with one write port, a
//           combinational cell read for the scanner and a registered row read.
// Rev     : 1.0  initial release
// ============================================================================
module cell_board #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [1:0]              wr_data,
    input  logic [$clog2(ROWS)-1:0] cell_row,
    input  logic [$clog2(COLS)-1:0] cell_col,
    output logic [1:0]              cell_data,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [2*COLS-1:0]       rd_data
);

    logic [2*COLS-1:0] r_rows [ROWS];
    logic [2*COLS-1:0] r_rd_data;

    assign cell_data = r_rows[cell_row][{cell_col, 1'b0} +: 2];
    assign rd_data   = r_rd_data;

    // Row read samples pre-write contents, so a same-cycle write returns the old row
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < ROWS; i++) begin
                r_rows[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (wr_en) begin
                r_rows[wr_row][{wr_col, 1'b0} +: 2] <= wr_data;
            end
            r_rd_data <= (int'(rd_row) < ROWS) ? r_rows[rd_row] : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/connect_n_engine.sv
`default_nettype none
// ============================================================================
// Module  : connect_n_engine
// Brief   : Gravity chip placement plus local four-direction connect-N scan
//           reporting win, draw or continue for each accepted drop.
// Rev     : 1.0  initial release
// ============================================================================
module connect_n_engine
    import connect_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    drop_valid,
    output logic                    drop_ready,
    input  logic [$clog2(COLS)-1:0] drop_col,
    input  logic                    drop_player,
    output logic                    done,
    output logic [1:0]              result,
    output logic                    reject,
    output logic                    game_over,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [2*COLS-1:0]       rd_data
);

    localparam int c_rw   = $clog2(ROWS);
    localparam int c_cw   = $clog2(COLS);
    localparam int c_hw   = $clog2(ROWS + 1);
    localparam int c_nw   = $clog2(ROWS * COLS + 1);
    localparam int c_runw = $clog2(WIN_LEN + 1);
    localparam int c_sw   = $clog2(WIN_LEN);
    localparam int c_rsw  = c_rw + 1;
    localparam int c_csw  = c_cw + 1;

    localparam logic [c_hw-1:0]   c_full_h  = c_hw'(ROWS);
    localparam logic [c_nw-1:0]   c_all     = c_nw'(ROWS * COLS);
    localparam logic [c_runw-1:0] c_win     = c_runw'(WIN_LEN);
    localparam logic [c_sw-1:0]   c_max_stp = c_sw'(WIN_LEN - 1);

    state_e                  r_state;
    dir_e                    r_dir;
    logic [c_cw-1:0]         r_col;
    logic                    r_player;
    logic [c_hw-1:0]         r_height [COLS];
    logic [c_nw-1:0]         r_count;
    logic [c_runw-1:0]       r_run;
    logic [c_sw-1:0]         r_steps;
    logic signed [c_rw:0]    r_prow;
    logic signed [c_cw:0]    r_pcol;
    logic signed [c_rw:0]    r_cr;
    logic signed [c_cw:0]    r_cc;
    logic                    r_done;
    logic [1:0]              r_result;
    logic                    r_reject;
    logic                    r_game_over;

    logic                    w_hs;
    logic                    w_col_ok;
    logic                    w_full;
    logic [1:0]              w_pcell;
    logic                    w_fwd;
    logic signed [1:0]       w_dr;
    logic signed [1:0]       w_dc;
    logic signed [c_rw:0]    w_nr;
    logic signed [c_cw:0]    w_nc;
    logic                    w_in;
    logic [1:0]              w_cell;
    logic                    w_match;
    logic [c_runw-1:0]       w_run_nxt;
    logic [c_sw-1:0]         w_stp_nxt;
    logic                    w_wr_en;
    logic [c_rw-1:0]         w_wr_row;

    assign drop_ready = (r_state == ST_IDLE) && !clear && !rst;
    assign done       = r_done;
    assign result     = r_result;
    assign reject     = r_reject;
    assign game_over  = r_game_over;

    assign w_hs     = drop_valid && drop_ready;
    assign w_col_ok = int'(drop_col) < COLS;
    assign w_full   = (r_height[drop_col] == c_full_h);
    assign w_pcell  = r_player ? c_cell_o : c_cell_g;
    assign w_wr_en  = (r_state == ST_PLACE);
    assign w_wr_row = r_height[r_col][c_rw-1:0];

    // Backward scan walks the negated step vector
    assign w_fwd = (r_state == ST_SCAN_FWD);
    assign w_dr  = w_fwd ? dir_dr(r_dir) : -dir_dr(r_dir);
    assign w_dc  = w_fwd ? dir_dc(r_dir) : -dir_dc(r_dir);
    assign w_nr  = r_cr + c_rsw'(w_dr);
    assign w_nc  = r_cc + c_csw'(w_dc);
    assign w_in  = !w_nr[c_rw] && (int'(w_nr) < ROWS) &&
                   !w_nc[c_cw] && (int'(w_nc) < COLS);

    assign w_match   = w_in && (w_cell == w_pcell);
    assign w_run_nxt = r_run + c_runw'(1);
    assign w_stp_nxt = r_steps + c_sw'(1);

    cell_board #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_board (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_en     (w_wr_en),
        .wr_row    (w_wr_row),
        .wr_col    (r_col),
        .wr_data   (w_pcell),
        .cell_row  (w_nr[c_rw-1:0]),
        .cell_col  (w_nc[c_cw-1:0]),
        .cell_data (w_cell),
        .rd_row    (rd_row),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= ST_IDLE;
            r_dir       <= DIR_H;
            r_col       <= '0;
            r_player    <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                r_height[i] <= '0;
            end
            r_count     <= '0;
            r_run       <= '0;
            r_steps     <= '0;
            r_prow      <= '0;
            r_pcol      <= '0;
            r_cr        <= '0;
            r_cc        <= '0;
            r_done      <= 1'b0;
            r_result    <= c_res_none;
            r_reject    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_col    <= drop_col;
                        r_player <= drop_player;
                        if (r_game_over || !w_col_ok || w_full) begin
                            r_state  <= ST_REJECT;
                            r_reject <= 1'b1;
                        end else begin
                            r_state <= ST_PLACE;
                        end
                    end
                end
                ST_PLACE: begin
                    r_height[r_col] <= r_height[r_col] + c_hw'(1);
                    r_count         <= r_count + c_nw'(1);
                    r_prow          <= {1'b0, w_wr_row};
                    r_pcol          <= {1'b0, r_col};
                    r_cr            <= {1'b0, w_wr_row};
                    r_cc            <= {1'b0, r_col};
                    r_run           <= c_runw'(1);
                    r_steps         <= '0;
                    r_dir           <= DIR_H;
                    r_state         <= ST_SCAN_FWD;
                end
                ST_SCAN_FWD, ST_SCAN_BWD: begin
                    if (w_match) begin
                        r_run   <= w_run_nxt;
                        r_steps <= w_stp_nxt;
                        r_cr    <= w_nr;
                        r_cc    <= w_nc;
                    end
                    if (w_match && (w_run_nxt >= c_win)) begin
                        r_state     <= ST_REPORT;
                        r_done      <= 1'b1;
                        r_result    <= r_player ? c_res_o_win : c_res_g_win;
                        r_game_over <= 1'b1;
                    end else if (!w_match || (w_stp_nxt == c_max_stp)) begin
                        // Run total carries over from the forward half into the backward half
                        r_steps <= '0;
                        r_cr    <= r_prow;
                        r_cc    <= r_pcol;
                        r_state <= w_fwd ? ST_SCAN_BWD : ST_NEXT_DIR;
                    end
                end
                ST_NEXT_DIR: begin
                    if (r_dir == DIR_D2) begin
                        r_state <= ST_REPORT;
                        r_done  <= 1'b1;
                        if (r_count == c_all) begin
                            r_result    <= c_res_draw;
                            r_game_over <= 1'b1;
                        end else begin
                            r_result <= c_res_none;
                        end
                    end else begin
                        r_dir   <= dir_e'(r_dir + 2'd1);
                        r_run   <= c_runw'(1);
                        r_steps <= '0;
                        r_cr    <= r_prow;
                        r_cc    <= r_pcol;
                        r_state <= ST_SCAN_FWD;
                    end
                end
                ST_REPORT: r_state <= ST_IDLE;
                ST_REJECT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
